// File: rtl/encoder_gate_scheduler.sv
// encoder_gate_scheduler
// Round-robin tachometer for four quadrature/tick encoder channels.
// Each scheduled measurement grants one enabled channel, counts its rising
// tick edges over a fixed gate window, scales the count down by the
// pulses-per-revolution shift, clips it to 11 bits and publishes it through
// a valid/ready handshake. Scheduling stalls while a result is pending.

module encoder_gate_scheduler #(
    parameter int GATE_CYCLES = 50000,
    parameter int PPR_SHIFT   = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  ticks,
    input  logic [3:0]  ch_en,
    input  logic        run,
    output logic [10:0] rpm_data,
    output logic [1:0]  rpm_ch,
    output logic        rpm_sat,
    output logic        rpm_valid,
    input  logic        rpm_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        GATE    = 2'd2,
        PUBLISH = 2'd3
    } state_t;

    localparam logic [15:0] LAST_TICK = 16'(GATE_CYCLES - 1);
    localparam logic [15:0] DATA_MAX  = 16'd2047;

    state_t      state;
    logic [3:0]  sync1;
    logic [3:0]  sync2;
    logic [3:0]  hist;
    logic [3:0]  edges;
    logic [1:0]  grant;
    logic [1:0]  last_grant;
    logic [15:0] count;
    logic [15:0] count_next;
    logic [15:0] timer;
    logic [15:0] scaled;
    logic [10:0] data_clip;
    logic        data_over;
    logic [1:0]  cand;
    logic [1:0]  pick;
    logic        pick_valid;
    logic        any_en;
    logic        gate_done;

    // Bring the raw tick lines into the CLK domain and keep one cycle of history for edge detection
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= 4'b0000;
            sync2 <= 4'b0000;
            hist  <= 4'b0000;
        end else begin
            sync1 <= ticks;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign edges     = sync2 & ~hist;
    assign any_en    = |ch_en;
    assign gate_done = (timer == LAST_TICK);

    // Round-robin pick: scan downward from the farthest offset so the nearest enabled channel after last_grant wins
    always_comb begin
        pick       = last_grant;
        pick_valid = 1'b0;
        cand       = 2'b00;
        for (int i = 4; i >= 1; i--) begin
            cand = last_grant + 2'(i);
            if (ch_en[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    // Next edge count for the granted channel, saturating at all-ones, plus the scaled and clipped result
    always_comb begin
        count_next = count;
        if (edges[grant] && (count != 16'hFFFF)) begin
            count_next = count + 16'd1;
        end
        scaled    = count_next >> PPR_SHIFT;
        data_over = (scaled > DATA_MAX);
        data_clip = data_over ? 11'h7FF : scaled[10:0];
    end

    // Scheduler FSM: idle, pick a channel, count over the gate window, then hold the result until it is taken
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            busy       <= 1'b0;
            rpm_valid  <= 1'b0;
            rpm_data   <= 11'd0;
            rpm_ch     <= 2'd0;
            rpm_sat    <= 1'b0;
            count      <= 16'd0;
            timer      <= 16'd0;
            grant      <= 2'd0;
            last_grant <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (run && any_en) begin
                        state <= SELECT;
                        busy  <= 1'b1;
                    end
                end

                SELECT: begin
                    count <= 16'd0;
                    timer <= 16'd0;
                    if (pick_valid) begin
                        grant      <= pick;
                        last_grant <= pick;
                        state      <= GATE;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                GATE: begin
                    count <= count_next;
                    if (gate_done) begin
                        rpm_data  <= data_clip;
                        rpm_sat   <= data_over;
                        rpm_ch    <= grant;
                        rpm_valid <= 1'b1;
                        state     <= PUBLISH;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end

                PUBLISH: begin
                    if (rpm_ready) begin
                        rpm_valid <= 1'b0;
                        if (run && any_en) begin
                            state <= SELECT;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    rpm_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_gate_scheduler.sv
// tb_encoder_gate_scheduler
// Directed and randomized bench for the encoder gate scheduler. A reference
// model derives the granted channel from the round-robin rule and the
// published value from the number of tick pulses the bench itself generates
// inside each gate window. A second instance with a long gate covers clipping.

module tb_encoder_gate_scheduler;

    localparam int G      = 100;
    localparam int G_LONG = 40000;

    logic        CLK;
    logic        RST;
    logic [3:0]  ticks;
    logic [3:0]  ch_en;
    logic        run;
    logic [10:0] rpm_data;
    logic [1:0]  rpm_ch;
    logic        rpm_sat;
    logic        rpm_valid;
    logic        rpm_ready;
    logic        busy;

    logic [3:0]  ticks2;
    logic [3:0]  ch_en2;
    logic        run2;
    logic [10:0] rpm_data2;
    logic [1:0]  rpm_ch2;
    logic        rpm_sat2;
    logic        rpm_valid2;
    logic        rpm_ready2;
    logic        busy2;

    int checks;
    int errors;
    int model_last;

    encoder_gate_scheduler #(.GATE_CYCLES(G), .PPR_SHIFT(3)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ticks     (ticks),
        .ch_en     (ch_en),
        .run       (run),
        .rpm_data  (rpm_data),
        .rpm_ch    (rpm_ch),
        .rpm_sat   (rpm_sat),
        .rpm_valid (rpm_valid),
        .rpm_ready (rpm_ready),
        .busy      (busy)
    );

    encoder_gate_scheduler #(.GATE_CYCLES(G_LONG), .PPR_SHIFT(3)) dut_long (
        .CLK       (CLK),
        .RST       (RST),
        .ticks     (ticks2),
        .ch_en     (ch_en2),
        .run       (run2),
        .rpm_data  (rpm_data2),
        .rpm_ch    (rpm_ch2),
        .rpm_sat   (rpm_sat2),
        .rpm_valid (rpm_valid2),
        .rpm_ready (rpm_ready2),
        .busy      (busy2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int next_grant(input int last, input logic [3:0] en);
        for (int i = 1; i <= 4; i++) begin
            if (en[(last + i) % 4]) return (last + i) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] noise_except(input int ch);
        logic [3:0] n;
        n = 4'($urandom);
        n[ch] = 1'b0;
        return n;
    endfunction

    // Called at the falling edge right after the cycle where the block entered SELECT.
    task automatic applyStimulus(input int n_edges, input int ready_delay, input logic drop_mid,
                                 input logic [3:0] en_after, input logic run_after);
        int         exp_ch;
        int         cyc;
        int         q;
        logic [10:0] exp_data;
        logic        exp_sat;
        exp_ch = next_grant(model_last, ch_en);
        model_last = exp_ch;
        q = n_edges / 8;
        exp_sat  = (q > 2047);
        exp_data = exp_sat ? 11'd2047 : 11'(q);
        rpm_ready = (ready_delay == 0);
        cyc = 0;
        ticks = noise_except(exp_ch);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            cyc++;
            ticks = noise_except(exp_ch);
            if (drop_mid && cyc == 2) begin
                run   = 1'b0;
                ch_en = 4'b0000;
            end
        end
        for (int i = 0; i < n_edges; i++) begin
            @(negedge CLK);
            cyc++;
            ticks = noise_except(exp_ch);
            ticks[exp_ch] = 1'b1;
            @(negedge CLK);
            cyc++;
            ticks = noise_except(exp_ch);
        end
        while (rpm_valid !== 1'b1 && cyc < G + 20) begin
            @(negedge CLK);
            cyc++;
            ticks = noise_except(exp_ch);
        end
        checkOutput("latency", cyc, G + 1);
        checkOutput("valid", rpm_valid, 1'b1);
        checkOutput("data", rpm_data, exp_data);
        checkOutput("ch", rpm_ch, exp_ch);
        checkOutput("sat", rpm_sat, exp_sat);
        checkOutput("busy_pub", busy, 1'b1);
        for (int d = 0; d < ready_delay; d++) begin
            @(negedge CLK);
            ticks = 4'($urandom);
            checkOutput("hold_valid", rpm_valid, 1'b1);
            checkOutput("hold_data", rpm_data, exp_data);
            checkOutput("hold_ch", rpm_ch, exp_ch);
            checkOutput("hold_sat", rpm_sat, exp_sat);
            checkOutput("hold_busy", busy, 1'b1);
        end
        rpm_ready = 1'b1;
        ch_en = en_after;
        run   = run_after;
        ticks = 4'b0000;
        @(negedge CLK);
        checkOutput("valid_drop", rpm_valid, 1'b0);
        checkOutput("busy_after", busy, (run_after && en_after != 4'b0000));
        checkOutput("data_kept", rpm_data, exp_data);
        checkOutput("ch_kept", rpm_ch, exp_ch);
    endtask

    initial begin
        logic        bad;
        int          cyc;
        logic [3:0]  en_next;

        checks     = 0;
        errors     = 0;
        model_last = 3;
        RST        = 1'b1;
        ticks      = 4'b0000;
        ch_en      = 4'b0000;
        run        = 1'b0;
        rpm_ready  = 1'b0;
        ticks2     = 4'b0000;
        ch_en2     = 4'b0000;
        run2       = 1'b0;
        rpm_ready2 = 1'b0;

        $display("[TB] reset state");
        repeat (3) @(negedge CLK);
        checkOutput("rst_valid", rpm_valid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_data", rpm_data, 11'd0);
        checkOutput("rst_ch", rpm_ch, 2'd0);
        checkOutput("rst_sat", rpm_sat, 1'b0);
        RST = 1'b0;

        $display("[TB] run with no channel enabled");
        run = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            ticks = 4'($urandom);
            if (busy !== 1'b0 || rpm_valid !== 1'b0) bad = 1'b1;
        end
        checkOutput("idle_no_en", bad, 1'b0);
        ticks = 4'b0000;

        $display("[TB] single channel, 40 edges");
        ch_en = 4'b0001;
        @(negedge CLK);
        applyStimulus(40, 0, 1'b0, 4'b1010, 1'b1);

        $display("[TB] round robin over channels 1 and 3");
        applyStimulus($urandom_range(8, 44), 0, 1'b0, 4'b1010, 1'b1);
        applyStimulus($urandom_range(8, 44), 20, 1'b0, 4'b1010, 1'b1);
        applyStimulus($urandom_range(8, 44), 0, 1'b0, 4'b1010, 1'b1);
        applyStimulus($urandom_range(8, 44), 3, 1'b0, 4'b1010, 1'b1);

        $display("[TB] run and enable dropped mid-gate");
        applyStimulus($urandom_range(8, 44), 0, 1'b1, 4'b0010, 1'b0);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (busy !== 1'b0 || rpm_valid !== 1'b0) bad = 1'b1;
        end
        checkOutput("idle_after_drop", bad, 1'b0);

        $display("[TB] reset in the middle of a gate");
        run = 1'b1;
        @(negedge CLK);
        cyc = 0;
        while (cyc < 50) begin
            @(negedge CLK);
            cyc++;
            ticks[1] = ~ticks[1];
        end
        #2;
        RST   = 1'b1;
        ticks = 4'b0000;
        #1;
        checkOutput("arst_valid", rpm_valid, 1'b0);
        checkOutput("arst_busy", busy, 1'b0);
        checkOutput("arst_data", rpm_data, 11'd0);
        checkOutput("arst_ch", rpm_ch, 2'd0);
        checkOutput("arst_sat", rpm_sat, 1'b0);
        model_last = 3;
        @(negedge CLK);
        checkOutput("arst_hold_valid", rpm_valid, 1'b0);
        ch_en = 4'b1111;
        run   = 1'b1;
        RST   = 1'b0;
        @(negedge CLK);
        applyStimulus($urandom_range(8, 44), 0, 1'b0, 4'b0000, 1'b0);

        $display("[TB] randomized enables and backpressure");
        ch_en = 4'($urandom_range(1, 15));
        run   = 1'b1;
        @(negedge CLK);
        for (int k = 0; k < 6; k++) begin
            en_next = (k == 5) ? 4'b0000 : 4'($urandom_range(1, 15));
            applyStimulus($urandom_range(0, 44), $urandom_range(0, 4), 1'b0, en_next, (k != 5));
        end

        $display("[TB] long gate clipping");
        ch_en2     = 4'b0001;
        run2       = 1'b1;
        rpm_ready2 = 1'b1;
        cyc = 0;
        while (rpm_valid2 !== 1'b1 && cyc < G_LONG + 100) begin
            @(negedge CLK);
            cyc++;
            ticks2[0] = ~ticks2[0];
        end
        checkOutput("long_valid", rpm_valid2, 1'b1);
        checkOutput("long_data", rpm_data2, 11'd2047);
        checkOutput("long_sat", rpm_sat2, 1'b1);
        checkOutput("long_ch", rpm_ch2, 2'd0);
        run2 = 1'b0;
        @(negedge CLK);
        checkOutput("long_valid_drop", rpm_valid2, 1'b0);
        checkOutput("long_busy", busy2, 1'b0);
        checkOutput("long_data_kept", rpm_data2, 11'd2047);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/encoder_gate_scheduler.md
ENCODER_GATE_SCHEDULER -- requirements
Module: encoder_gate_scheduler

Interface
REQ-001 SHALL provide parameter GATE_CYCLES, default 50000: gate window length in CLK cycles, legal 1..65535.
REQ-002 SHALL provide parameter PPR_SHIFT, default 3: right-shift applied to the edge count (divide by 8).
REQ-003 SHALL have port CLK  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ticks  input  4  raw encoder tick lines, asynchronous to CLK.
REQ-006 SHALL have port ch_en  input  4  per-channel measurement enable.
REQ-007 SHALL have port run  input  1  level; 1 = keep scheduling measurements.
REQ-008 SHALL have port rpm_data  output  11  measured value.
REQ-009 SHALL have port rpm_ch  output  2  channel index of rpm_data.
REQ-010 SHALL have port rpm_sat  output  1  1 = rpm_data clipped to 2047.
REQ-011 SHALL have port rpm_valid  output  1  result available.
REQ-012 SHALL have port rpm_ready  input  1  consumer accepts result.
REQ-013 SHALL have port busy  output  1  1 whenever state is not IDLE.

Function
REQ-014 SHALL pass each ticks bit through a 2-flop synchronizer plus one history flop, always running, independent of state.
REQ-015 SHALL define an edge as synchronized value 1 with history 0 on the same cycle.
REQ-016 SHALL implement states IDLE, SELECT, GATE, PUBLISH.
REQ-017 IDLE -> SELECT when run=1 and ch_en!=0; otherwise SHALL remain IDLE.
REQ-018 SELECT (1 cycle) SHALL grant the first enabled channel strictly after last_grant, wrapping 3->0 (round-robin), clear count and gate timer, then go to GATE.
REQ-019 GATE SHALL last exactly GATE_CYCLES cycles and increment the 16-bit count once per cycle the granted channel shows an edge.
REQ-020 Count SHALL saturate at 16'hFFFF and never wrap.
REQ-021 Edges on the granted channel during IDLE, SELECT or PUBLISH SHALL not be counted; edges on non-granted channels SHALL always be ignored.
REQ-022 On the last GATE cycle the block SHALL register q = count >> PPR_SHIFT; rpm_data = min(q, 2047), rpm_sat = (q > 2047), rpm_ch = grant, and enter PUBLISH.
REQ-023 rpm_valid SHALL be 1 exactly while in PUBLISH, first asserted the cycle after the last GATE cycle.
REQ-024 rpm_data, rpm_ch, rpm_sat SHALL be stable while rpm_valid=1 and rpm_ready=0.
REQ-025 Transfer SHALL occur on a cycle with rpm_valid=1 and rpm_ready=1; rpm_valid SHALL not depend combinationally on rpm_ready.
REQ-026 After transfer: to SELECT if run=1 and ch_en!=0, else IDLE.
REQ-027 No new gate SHALL start while a result is untransferred (backpressure stalls scheduling).
REQ-028 Deasserting run or clearing the granted ch_en bit during GATE SHALL not abort; the measurement completes and is published.
REQ-029 Outputs rpm_data, rpm_ch, rpm_sat SHALL hold last published values outside PUBLISH.

Reset
REQ-030 RST=1 SHALL immediately force IDLE, rpm_valid=0, busy=0, rpm_data=0, rpm_ch=0, rpm_sat=0, count=0, timer=0, synchronizer and history flops=0.
REQ-031 last_grant SHALL reset to 3 so the first grant with ch_en[0]=1 is channel 0.
REQ-032 RST asserted mid-GATE or mid-PUBLISH SHALL discard the measurement; no result transfers.

Verification (GATE_CYCLES=100 unless stated)
REQ-033 ch_en=0001, run=1, rpm_ready=1, 40 rising edges on ticks[0] inside gate -> rpm_valid one cycle, rpm_ch=0, rpm_data=5, rpm_sat=0.
REQ-034 ch_en=1010, run=1, rpm_ready=1 -> successive grants 1,3,1,3; rpm_ch sequence matches.
REQ-035 rpm_ready=0 for 20 cycles after rpm_valid -> rpm_valid, rpm_data, rpm_ch unchanged all 20 cycles; busy=1; no SELECT until ready=1.
REQ-036 GATE_CYCLES=40000, ticks[0] toggling every cycle -> 20000 edges, q=2500 -> rpm_data=2047, rpm_sat=1.
REQ-037 RST pulse at gate cycle 50 -> all outputs 0 asynchronously; after release next grant is channel 0, first result from a full fresh gate.
REQ-038 run=1, ch_en=0000 for 200 cycles -> remains IDLE, busy=0, rpm_valid=0; run dropped mid-GATE -> one result published, then IDLE.
